// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU
// load/store unit (port 0) and a debug/DMA master (port 1).
// Each access takes IDLE -> SERVE -> RESP: one memory cycle, then one ack cycle.
module dm_arbiter #(
  parameter int unsigned DM_BYTES = 4096
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        we0,
  input  logic [1:0]  size0,
  input  logic [31:0] pc0,
  output logic        ack0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic        we1,
  input  logic [1:0]  size1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic [31:0] dm_A,
  output logic [31:0] dm_WD,
  output logic        dm_DMWr,
  output logic [1:0]  dm_SSel,
  output logic [1:0]  dm_LSel,
  output logic [31:0] dm_PC,
  input  logic [31:0] dm_RD,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

  localparam logic [31:0] DM_LIMIT = 32'(DM_BYTES);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        sel;

  // Misaligned, illegal-size or out-of-range accesses are rejected.
  function automatic logic access_err(input logic [31:0] a, input logic [1:0] sz);
    access_err = (sz == 2'b11)
               | ((sz == 2'b00) & (a[1:0] != 2'b00))
               | ((sz == 2'b01) & a[0])
               | (a >= DM_LIMIT);
  endfunction

  // Next-state logic: grant and latch in IDLE, capture read data in SERVE.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    size_d   = size_q;
    pc_d     = pc_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    sel      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          // With both requesting, the port that did not win last time goes next.
          sel     = (req0 & req1) ? ~last_q : req1;
          gnt_d   = sel;
          last_d  = sel;
          addr_d  = sel ? addr1  : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          we_d    = sel ? we1    : we0;
          size_d  = sel ? size1  : size0;
          pc_d    = sel ? 32'd0  : pc0;
          err_d   = sel ? access_err(addr1, size1) : access_err(addr0, size0);
          state_d = SERVE;
        end
      end
      SERVE: begin
        if (gnt_q) rdata1_d = (we_q | err_q) ? 32'd0 : dm_RD;
        else       rdata0_d = (we_q | err_q) ? 32'd0 : dm_RD;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched-request registers; reset aborts any in-flight access.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      pc_q     <= 32'd0;
      err_q    <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      size_q   <= size_d;
      pc_q     <= pc_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Outputs decoded from state so the write strobe drops with reset.
  always_comb begin
    dm_A    = addr_q;
    dm_WD   = wdata_q;
    dm_SSel = size_q;
    dm_LSel = size_q;
    dm_PC   = pc_q;
    dm_DMWr = (state_q == SERVE) & we_q & ~err_q;
    ack0    = (state_q == RESP) & ~gnt_q;
    ack1    = (state_q == RESP) & gnt_q;
    err0    = ack0 & err_q;
    err1    = ack1 & err_q;
    rdata0  = rdata0_q;
    rdata1  = rdata1_q;
    busy    = (state_q != IDLE);
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a byte-addressed memory model on the
// shared port (little-endian, sign-extending loads).
module tb_dm_arbiter;

  logic        Clk, Rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, pc0, addr1, wdata1;
  logic [1:0]  size0, size1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] dm_A, dm_WD, dm_PC, dm_RD;
  logic        dm_DMWr, busy;
  logic [1:0]  dm_SSel, dm_LSel;

  int checks = 0;
  int failures = 0;

  dm_arbiter #(.DM_BYTES(4096)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .size0(size0), .pc0(pc0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .size1(size1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .dm_A(dm_A), .dm_WD(dm_WD), .dm_DMWr(dm_DMWr), .dm_SSel(dm_SSel),
    .dm_LSel(dm_LSel), .dm_PC(dm_PC), .dm_RD(dm_RD), .busy(busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model
  logic [7:0] mem [0:4095];
  logic [11:0] ma;
  assign ma = dm_A[11:0];

  always @(posedge Clk) begin
    if (dm_DMWr) begin
      mem[ma] <= dm_WD[7:0];
      if (dm_SSel != 2'b10) mem[ma + 12'd1] <= dm_WD[15:8];
      if (dm_SSel == 2'b00) begin
        mem[ma + 12'd2] <= dm_WD[23:16];
        mem[ma + 12'd3] <= dm_WD[31:24];
      end
    end
  end

  always_comb begin
    case (dm_LSel)
      2'b00:   dm_RD = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
      2'b01:   dm_RD = {{16{mem[ma + 12'd1][7]}}, mem[ma + 12'd1], mem[ma]};
      2'b10:   dm_RD = {{24{mem[ma][7]}}, mem[ma]};
      default: dm_RD = 32'd0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic [31:0] pc;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [12];

  task automatic idle_inputs();
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; size0 = 0; pc0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; size1 = 0;
  endtask

  // Starts at a negedge with the DUT idle; ends at a negedge with it idle again.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    if (v.port) begin
      req1 = 1; addr1 = v.addr; wdata1 = v.wdata; we1 = v.we; size1 = v.size;
    end else begin
      req0 = 1; addr0 = v.addr; wdata0 = v.wdata; we0 = v.we; size0 = v.size; pc0 = v.pc;
    end
    @(negedge Clk);
    chk({tag, " serve DMWr"}, 32'(dm_DMWr), 32'(v.we & ~v.exp_err));
    chk({tag, " serve A"}, dm_A, v.addr);
    chk({tag, " serve WD"}, dm_WD, v.wdata);
    chk({tag, " serve SSel"}, 32'(dm_SSel), 32'(v.size));
    chk({tag, " serve PC"}, dm_PC, v.port ? 32'd0 : v.pc);
    chk({tag, " serve noack"}, 32'({ack0, ack1}), 32'd0);
    chk({tag, " serve busy"}, 32'(busy), 32'd1);
    @(negedge Clk);
    chk({tag, " resp DMWr"}, 32'(dm_DMWr), 32'd0);
    if (v.port) begin
      chk({tag, " resp acks"}, 32'({ack0, ack1}), 32'b01);
      chk({tag, " resp err1"}, 32'(err1), 32'(v.exp_err));
      chk({tag, " resp rdata1"}, rdata1, v.exp_rd);
    end else begin
      chk({tag, " resp acks"}, 32'({ack0, ack1}), 32'b10);
      chk({tag, " resp err0"}, 32'(err0), 32'(v.exp_err));
      chk({tag, " resp rdata0"}, rdata0, v.exp_rd);
    end
    req0 = 0; req1 = 0;
    @(negedge Clk);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle acks"}, 32'({ack0, ack1}), 32'd0);
  endtask

  initial begin
    //          port addr          wdata         we size   pc            err rdata
    vecs[0]  = '{1'b0, 32'h10,    32'hDEADBEEF, 1, 2'b00, 32'h400, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h13,    32'h0,        0, 2'b10, 32'h0,   1'b0, 32'hFFFFFFDE};
    vecs[2]  = '{1'b0, 32'h12,    32'h0,        0, 2'b01, 32'h404, 1'b0, 32'hFFFFDEAD};
    vecs[3]  = '{1'b1, 32'h10,    32'h0,        0, 2'b00, 32'h0,   1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 32'h21,    32'h0000ABCD, 1, 2'b01, 32'h408, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h1000,  32'h0,        0, 2'b00, 32'h0,   1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h0,     32'h0,        0, 2'b11, 32'h40C, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 32'h20,    32'h12345678, 1, 2'b00, 32'h0,   1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h21,    32'h0,        0, 2'b10, 32'h410, 1'b0, 32'h56};
    vecs[9]  = '{1'b1, 32'h22,    32'h0,        0, 2'b00, 32'h0,   1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h13,    32'h0,        0, 2'b10, 32'h414, 1'b0, 32'hFFFFFFDE};
    vecs[11] = '{1'b1, 32'h20,    32'h0,        0, 2'b00, 32'h0,   1'b0, 32'h12345678};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    idle_inputs();

    // Both requesters held high straight out of reset.
    Rst = 0;
    req0 = 1; addr0 = 32'h10; size0 = 2'b00; pc0 = 32'h100;
    req1 = 1; addr1 = 32'h20; size1 = 2'b00;
    repeat (2) @(negedge Clk);
    chk("reset acks", 32'({ack0, ack1}), 32'd0);
    chk("reset errs", 32'({err0, err1}), 32'd0);
    chk("reset DMWr", 32'(dm_DMWr), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset rdata0", rdata0, 32'd0);
    chk("reset rdata1", rdata1, 32'd0);
    Rst = 1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge Clk);
      chk($sformatf("rr cycle%0d acks", c), 32'({ack0, ack1}),
          (c == 2 || c == 8) ? 32'b10 : (c == 5) ? 32'b01 : 32'b00);
    end
    idle_inputs();
    repeat (2) @(negedge Clk);

    // Table-driven single-port accesses.
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
    chk("rdata0 held", rdata0, 32'hFFFFFFDE);
    chk("misaligned store not written", 32'(mem[12'h21]), 32'h56);

    // Reset asserted while a write is in SERVE.
    req0 = 1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D; we0 = 1; size0 = 2'b00; pc0 = 32'h500;
    @(negedge Clk);
    chk("abort serve DMWr", 32'(dm_DMWr), 32'd1);
    #2 Rst = 0;
    #1;
    chk("abort DMWr drops", 32'(dm_DMWr), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rdata0 cleared", rdata0, 32'd0);
    req0 = 0; we0 = 0;
    repeat (2) @(negedge Clk);
    Rst = 1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge Clk);
      chk($sformatf("abort cycle%0d acks", c), 32'({ack0, ack1}), 32'd0);
      chk($sformatf("abort cycle%0d busy", c), 32'(busy), 32'd0);
    end
    chk("abort no write", {mem[12'h33], mem[12'h32], mem[12'h31], mem[12'h30]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single data-memory port (A, WD, DMWr, SSel, LSel, RD, PC) between two requesters.
- Port 0 is the CPU load/store unit; port 1 is a debug/DMA master.
- Arbitration is round-robin, with a 3-state sequencer and a req/ack handshake per port.
- Misaligned or out-of-range accesses are rejected with an error response and are never written.

Parameters:
- DM_BYTES, 4096: size of the data memory in bytes. Any address with addr >= DM_BYTES is out of range.

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- Rst  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; fields held stable until ack0.
- addr0  in  32  port 0 byte address.
- wdata0  in  32  port 0 store data, right-aligned.
- we0  in  1  port 0 write (1) / read (0).
- size0  in  2  port 0 size: 00 word, 01 half, 10 byte, 11 illegal.
- pc0  in  32  port 0 instruction PC, used for the memory write log.
- ack0  out  1  port 0 one-cycle completion pulse.
- rdata0  out  32  port 0 load data; valid while ack0=1.
- err0  out  1  port 0 error flag; valid while ack0=1.
- req1, addr1, wdata1, we1, size1, ack1, rdata1, err1: same as port 0. Port 1 has no PC input.
- dm_A  out  32  memory byte address.
- dm_WD  out  32  memory write data.
- dm_DMWr  out  1  memory write enable.
- dm_SSel  out  2  memory store size select (= size).
- dm_LSel  out  2  memory load size select (= size).
- dm_PC  out  32  PC for the memory log: latched pc0 for port 0, 0 for port 1.
- dm_RD  in  32  memory read data (combinational, sign-extended by memory).
- busy  out  1  1 when the FSM is not in IDLE.

Behaviour:
- Reset (Rst=0, asynchronous):
  - state=IDLE; last_grant=1.
  - All ack, err and dm_DMWr = 0; rdata regs = 0; latched request = 0.
  - dm_DMWr must drop in the same cycle reset asserts (it is decoded from state).
  - Reset mid-SERVE aborts the access: no write and no ack.
- FSM states: IDLE -> SERVE -> RESP -> IDLE. Throughput is one access per 3 cycles.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port != last_grant.
  - On grant: latch addr, wdata, we, size and pc; set last_grant=granted port; go to SERVE.
  - Error check at latch: err_l = (size==11) | (size==00 & addr[1:0]!=0) | (size==01 & addr[0]!=0) | (addr >= DM_BYTES).
- SERVE (exactly 1 cycle):
  - dm_A, dm_WD, dm_SSel, dm_LSel and dm_PC are driven from the latched request.
  - dm_DMWr = we_l & ~err_l.
  - At the posedge ending SERVE: capture dm_RD into the granted port's rdata reg (0 if we_l or err_l); go to RESP.
- RESP (exactly 1 cycle):
  - ack of the granted port = 1; its err = err_l; the other port's ack = 0.
  - Requests are ignored in this state; next state is IDLE.
- Handshake rules:
  - Requester samples ack at the posedge ending RESP, then may drop req or present a new request.
  - A request still high in IDLE after its ack is treated as a new access.
  - Requests must not change fields while req=1 and no ack has been received; doing so is undefined.
- Outside SERVE: dm_DMWr=0; dm_A, dm_WD and dm_PC hold the latched values.
- Latency: req seen in IDLE at cycle 0 -> ack at cycle 2.
- A losing requester waits at most one full access (3 cycles) under round-robin.
- rdata holds its value until the next access for that port.

Test Plan:
- Port 0 word write: addr0=0x10, wdata0=0xDEADBEEF, we0=1, size0=00 -> dm_DMWr=1 for exactly one cycle with dm_A=0x10; ack0 two cycles after req; err0=0.
- Port 1 byte read after that write: addr1=0x13, we1=0, size1=10 -> ack1 with rdata1=0xFFFFFFDE, err1=0.
- Both requesters asserted from reset, both held high -> grant order is port 0, port 1, port 0; each ack is 3 cycles apart; no cycle has both acks high.
- Misaligned half store: addr0=0x21, size0=01, we0=1 -> dm_DMWr stays 0; ack0=1 with err0=1. Out-of-range word read at addr1=0x1000 -> err1=1, rdata1=0.
- Reset pulled low during SERVE of a write -> dm_DMWr falls immediately; no ack; after release, state=IDLE and busy=0.
- size=11 read request -> err=1; the transaction still completes in 3 cycles.
